sail_print_arbiter: RTL and testbench
=====================================

// Module: sail_print_arbiter
// PURPOSE
//  Shares the single Sail stdout byte sink between NUM_REQ print requesters.
//  Each requester sends one message as a valid/ready byte stream ending in a last beat.
//  Requesters are granted round-robin on message boundaries, so messages never interleave.
//  An optional trailing "\n" is appended, giving the same result as print_endline vs print.
// PARAMETERS
//  NUM_REQ   4      number of requesters (2..16)
//  DATA_W    8      byte width of message beats
//  NEWLINE   8'h0A  byte emitted for endline
//  CNT_W     16     width of the completed-message counter
// PORTS
//  clk           in   1                 rising-edge clock
//  reset         in   1                 synchronous, active-high reset
//  req_valid     in   NUM_REQ           per-requester beat valid
//  req_data      in   NUM_REQ*DATA_W    beat data; requester i at [i*DATA_W +: DATA_W]
//  req_last      in   NUM_REQ           beat is the final byte of the message
//  req_endline   in   NUM_REQ           sampled with last beat: append NEWLINE
//  req_ready     out  NUM_REQ           beat accepted when valid&ready
//  out_valid     out  1                 sink beat valid
//  out_data      out  DATA_W            sink beat data
//  out_last      out  1                 final beat of message (incl. appended newline)
//  out_ready     in   1                 sink accepts beat
//  grant_id      out  $clog2(NUM_REQ)   current owner; valid while busy
//  busy          out  1                 FSM not in IDLE
//  msg_count     out  CNT_W             completed messages, wraps at 2^CNT_W
// BEHAVIOUR
//  - FSM states: IDLE, PASS, NL.
//  - IDLE: outputs idle. If any req_valid is set, pick the first set bit searching from rr_ptr upward, wrapping.
//    Register it as grant_id and go to PASS (1 cycle arbitration latency).
//  - PASS: combinational path for granted g only:
//    out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready; other req_ready=0.
//    out_last=req_last[g] & ~req_endline[g].
//  - On an accepted beat with req_last[g]=1:
//    if req_endline[g]=1 go to NL; else go to IDLE, rr_ptr<=g+1 (mod NUM_REQ), msg_count++.
//  - NL: out_valid=1, out_data=NEWLINE, out_last=1, all req_ready=0.
//    On out_ready: go to IDLE, rr_ptr<=g+1, msg_count++.
//  - Backpressure: out_ready=0 holds state; beats are neither lost nor duplicated.
//  - Owner gap: req_valid[g] may drop mid-message. out_valid then drops, the grant is kept, and there is no timeout.
//  - Requests from other requesters are ignored until the message completes.
//  - An empty message is a single last beat. A zero-length message is not supported.
//  - Wrap: rr_ptr wraps NUM_REQ-1 -> 0. msg_count wraps 2^CNT_W-1 -> 0.
//  - Reset (any state, incl. mid-message): next edge gives state=IDLE, rr_ptr=0, grant_id=0, msg_count=0.
//    In-flight message is abandoned and the sink sees no out_last.
//  - Reset values: out_valid=0, req_ready=0, out_last=0, busy=0, out_data=0, grant_id=0, msg_count=0.
//  - No combinational path from out_ready to out_valid. The req_ready[g] <- out_ready path is combinational.
// TESTING
//  1. Req1 sends "hi" last, endline=0; out_ready=1.
//     -> Beats 'h','i' with out_last on 'i', grant_id=1, msg_count=1, 1-cycle gap after request.
//  2. Req0 sends "ok" with endline=1.
//     -> Sink sees 'o','k',8'h0A; out_last only on 8'h0A; msg_count+1.
//  3. All 4 requesters valid continuously, 1-byte messages.
//     -> Grant order 0,1,2,3,0,... with no requester granted twice in a row.
//  4. Req2 mid-message; toggle out_ready 1,0,0,1 and drop req_valid[2] for 3 cycles while req3 valid.
//     -> Byte order kept, grant stays 2, req_ready[3]=0 throughout.
//  5. Assert reset during NL state.
//     -> Next cycle: busy=0, out_valid=0, msg_count=0. Next arbitration starts at requester 0.
//  6. Preload msg_count to 16'hFFFF via 65535 messages, then complete one more.
//     -> msg_count=0.

Source files
------------

// File: rtl/sail_print_arbiter.sv
// ---------------------------------------------------------------------------
// sail_print_arbiter
//   Shares one Sail stdout byte sink among NUM_REQ print requesters. Each
//   requester streams one message as valid/ready bytes ending in a last beat.
//   Grants are round-robin and only change on message boundaries, so messages
//   never interleave. A requester may ask for a trailing NEWLINE byte
//   (print_endline) by raising req_endline together with its last beat.
//
//   State table
//     state   | meaning
//     --------+-----------------------------------------------------------
//     ST_IDLE | no owner; arbitrate among req_valid starting at rr_ptr
//     ST_PASS | granted requester's beats pass straight through to the sink
//     ST_NL   | emitting the appended NEWLINE byte that closes the message
//
//   Ports
//     clk          rising-edge clock
//     reset        synchronous active-high reset
//     req_valid    per-requester beat valid
//     req_data     beat data, requester i at [i*DATA_W +: DATA_W]
//     req_last     beat is the final byte of the message
//     req_endline  sampled with the last beat: append NEWLINE
//     req_ready    per-requester beat accept (only the owner can be ready)
//     out_valid    sink beat valid
//     out_data     sink beat data
//     out_last     final sink beat of the message (incl. appended newline)
//     out_ready    sink accepts beat
//     grant_id     current owner, meaningful while busy
//     busy         a message is in progress
//     msg_count    completed messages, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module sail_print_arbiter #(
    parameter int                 NUM_REQ = 4,
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  NEWLINE = DATA_W'(8'h0A),
    parameter int                 CNT_W   = 16,
    localparam int                GW      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ-1:0]          req_endline,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [GW-1:0]               grant_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            msg_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_NL   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       w_grant_next;
    logic [GW-1:0]       r_rr_ptr;
    logic [GW-1:0]       w_rr_next;
    logic [GW-1:0]       w_rr_after;
    logic [CNT_W-1:0]    r_msg_count;
    logic [CNT_W-1:0]    w_cnt_next;

    logic                w_pick_found;
    logic [GW-1:0]       w_pick_id;

    logic                w_out_valid;
    logic [DATA_W-1:0]   w_out_data;
    logic                w_out_last;
    logic [NUM_REQ-1:0]  w_req_ready;

    logic [DATA_W-1:0]   w_req_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    // The sum is one bit wider so the wrap works for non-power-of-two counts.
    always_comb begin : p_pick
        logic [GW:0] w_sum;
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_sum        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (GW+1)'(NUM_REQ);
            end
            if (!w_pick_found && req_valid[w_sum[GW-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_sum[GW-1:0];
            end
        end
    end

    // Pointer moves past the owner that just finished, so it cannot win twice
    // in a row while others are waiting.
    assign w_rr_after = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin : p_fsm
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr_ptr;
        w_cnt_next   = r_msg_count;
        w_out_valid  = 1'b0;
        w_out_data   = '0;
        w_out_last   = 1'b0;
        w_req_ready  = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_grant_next = w_pick_id;
                    w_state_next = ST_PASS;
                end
            end

            ST_PASS: begin
                // out_valid depends only on the owner's valid, never on out_ready.
                w_out_valid          = req_valid[r_grant];
                w_out_data           = w_req_bytes[r_grant];
                w_out_last           = req_last[r_grant] & ~req_endline[r_grant];
                w_req_ready[r_grant] = out_ready;
                if (req_valid[r_grant] && out_ready && req_last[r_grant]) begin
                    if (req_endline[r_grant]) begin
                        w_state_next = ST_NL;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_rr_next    = w_rr_after;
                        w_cnt_next   = r_msg_count + 1'b1;
                    end
                end
            end

            ST_NL: begin
                w_out_valid = 1'b1;
                w_out_data  = NEWLINE;
                w_out_last  = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                    w_rr_next    = w_rr_after;
                    w_cnt_next   = r_msg_count + 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_msg_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_rr_ptr    <= w_rr_next;
            r_msg_count <= w_cnt_next;
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;
    assign out_last  = w_out_last;
    assign req_ready = w_req_ready;
    assign grant_id  = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign msg_count = r_msg_count;

endmodule

// File: tb/tb_sail_print_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sail_print_arbiter
//   Directed bench for sail_print_arbiter. NUM_REQ=4, DATA_W=8. The message
//   counter is built 8 bits wide here so its wrap (255 -> 0) is reached in a
//   few hundred cycles instead of 65536 messages.
// ---------------------------------------------------------------------------
module tb_sail_print_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 8;

    logic                       clk;
    logic                       reset;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_endline;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_last;
    logic                       out_ready;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic [CNT_W-1:0]           msg_count;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_cnt;

    sail_print_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .NEWLINE (8'h0A),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_endline (req_endline),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .msg_count   (msg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge and
    // outputs are checked 1 ns later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d,
                           input logic l, input logic e);
        req_valid[i]          = v;
        req_data[i*DATA_W +: DATA_W] = d;
        req_last[i]           = l;
        req_endline[i]        = e;
    endtask

    // All four requesters hold valid one-byte messages "0".."3".
    task automatic all_single();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
    endtask

    // One arbitration cycle plus one pass-through cycle of a one-byte message.
    task automatic one_msg(input int exp_g);
        settle();
        chk("rr_idle_busy", {31'd0, busy}, 32'd0);
        chk("rr_idle_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("rr_grant", {30'd0, grant_id}, 32'(exp_g));
        chk("rr_data", {24'd0, out_data}, 32'h30 + 32'(exp_g));
        chk("rr_last", {31'd0, out_last}, 32'd1);
        chk("rr_ready", {28'd0, req_ready}, 32'd1 << exp_g);
        exp_cnt = exp_cnt + 1'b1;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        req_endline = '0;
        out_ready   = 1'b0;
        exp_cnt     = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_grant", {30'd0, grant_id}, 32'd0);
        chk("rst_count", {24'd0, msg_count}, 32'd0);
        reset = 1'b0;

        // 1: requester 1 prints "hi" without newline.
        out_ready = 1'b1;
        set_req(1, 1'b1, "h", 1'b0, 1'b0);
        settle();
        chk("t1_gap_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_gap_ready", {28'd0, req_ready}, 32'd0);
        tick();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_grant", {30'd0, grant_id}, 32'd1);
        chk("t1_h_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_h_data", {24'd0, out_data}, 32'h68);
        chk("t1_h_last", {31'd0, out_last}, 32'd0);
        chk("t1_h_ready", {28'd0, req_ready}, 32'b0010);
        tick();
        set_req(1, 1'b1, "i", 1'b1, 1'b0);
        settle();
        chk("t1_i_data", {24'd0, out_data}, 32'h69);
        chk("t1_i_last", {31'd0, out_last}, 32'd1);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0, 1'b0);
        exp_cnt = exp_cnt + 1'b1;
        settle();
        chk("t1_done_busy", {31'd0, busy}, 32'd0);
        chk("t1_count", {24'd0, msg_count}, 32'(exp_cnt));

        // 2: requester 0 prints "ok" with newline (rr_ptr is now 2).
        set_req(0, 1'b1, "o", 1'b0, 1'b0);
        settle();
        chk("t2_gap_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t2_grant", {30'd0, grant_id}, 32'd0);
        chk("t2_o_data", {24'd0, out_data}, 32'h6F);
        chk("t2_o_last", {31'd0, out_last}, 32'd0);
        tick();
        set_req(0, 1'b1, "k", 1'b1, 1'b1);
        settle();
        chk("t2_k_data", {24'd0, out_data}, 32'h6B);
        chk("t2_k_last", {31'd0, out_last}, 32'd0);
        tick();
        set_req(0, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        chk("t2_nl_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_nl_data", {24'd0, out_data}, 32'h0A);
        chk("t2_nl_last", {31'd0, out_last}, 32'd1);
        chk("t2_nl_ready", {28'd0, req_ready}, 32'd0);
        chk("t2_nl_busy", {31'd0, busy}, 32'd1);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        chk("t2_count", {24'd0, msg_count}, 32'(exp_cnt));
        chk("t2_done_busy", {31'd0, busy}, 32'd0);

        // 3: everyone valid; rr_ptr is 1 after requester 0 finished.
        all_single();
        for (int k = 0; k < 8; k++) one_msg((1 + k) % NUM_REQ);
        chk("t3_count", {24'd0, msg_count}, 32'(exp_cnt));

        // 4: rr_ptr is 1; requesters 2 and 3 compete, 2 wins. Backpressure
        //    and an owner gap must not let requester 3 in.
        req_valid = '0; req_last = '0; req_endline = '0;
        set_req(2, 1'b1, "A", 1'b0, 1'b0);
        set_req(3, 1'b1, "Z", 1'b1, 1'b0);
        tick();
        out_ready = 1'b1;
        settle();
        chk("t4_grant", {30'd0, grant_id}, 32'd2);
        chk("t4_A_data", {24'd0, out_data}, 32'h41);
        chk("t4_A_ready", {28'd0, req_ready}, 32'b0100);
        tick();
        set_req(2, 1'b1, "B", 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t4_bp_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_bp_data", {24'd0, out_data}, 32'h42);
            chk("t4_bp_ready", {28'd0, req_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        chk("t4_B_data", {24'd0, out_data}, 32'h42);
        chk("t4_B_ready", {28'd0, req_ready}, 32'b0100);
        tick();
        set_req(2, 1'b0, "C", 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t4_gap_valid", {31'd0, out_valid}, 32'd0);
            chk("t4_gap_grant", {30'd0, grant_id}, 32'd2);
            chk("t4_gap_ready3", {31'd0, req_ready[3]}, 32'd0);
            chk("t4_gap_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        set_req(2, 1'b1, "C", 1'b1, 1'b0);
        settle();
        chk("t4_C_data", {24'd0, out_data}, 32'h43);
        chk("t4_C_last", {31'd0, out_last}, 32'd1);
        chk("t4_C_grant", {30'd0, grant_id}, 32'd2);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        set_req(2, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("t4_next_grant", {30'd0, grant_id}, 32'd3);
        chk("t4_Z_data", {24'd0, out_data}, 32'h5A);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        set_req(3, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        chk("t4_count", {24'd0, msg_count}, 32'(exp_cnt));

        // 5: reset while stalled in NL (rr_ptr is 0; requester 1 alone).
        set_req(1, 1'b1, "x", 1'b1, 1'b1);
        tick();
        chk("t5_grant", {30'd0, grant_id}, 32'd1);
        tick();
        set_req(1, 1'b0, 8'h00, 1'b0, 1'b0);
        out_ready = 1'b0;
        settle();
        chk("t5_nl_data", {24'd0, out_data}, 32'h0A);
        reset = 1'b1;
        tick();
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_out_last", {31'd0, out_last}, 32'd0);
        chk("t5_count", {24'd0, msg_count}, 32'd0);
        chk("t5_grant_rst", {30'd0, grant_id}, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        exp_cnt   = '0;
        all_single();
        for (int k = 0; k < 5; k++) one_msg(k % NUM_REQ);

        // 6: run the counter up to 255, then one more message wraps it to 0.
        for (int k = 5; k < 255; k++) one_msg(k % NUM_REQ);
        chk("t6_count_max", {24'd0, msg_count}, 32'd255);
        one_msg(255 % NUM_REQ);
        chk("t6_count_wrap", {24'd0, msg_count}, 32'd0);
        chk("t6_model_wrap", {24'd0, msg_count}, 32'(exp_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
